// File: rtl/stoch_pkg.sv
// stoch_pkg
// Shared types and helpers for the stochastic-to-binary decoder.
//   stoch_dec_state_t : decoder control FSM states
//   out_width()       : result width for a window of 2^win_log2 samples
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } stoch_dec_state_t;

    // A window of 2^win_log2 ones needs one extra bit so the full count N is exact.
    function automatic int out_width(input int win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// stoch_ones_counter
// Counts sampled ones over windows of 2^WIN_LOG2 sampled cycles.
//   CLK    in   clock
//   nRST   in   asynchronous active-low reset
//   clear  in   synchronous clear of the partial window
//   sample in   take x on this edge (already qualified by clear in the top)
//   x      in   stochastic bit
//   done   out  this edge samples the last bit of the window
//   sum    out  window count including this edge's x (valid when done=1)
module stoch_ones_counter
    import stoch_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    localparam int OUT_W   = out_width(WIN_LOG2)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             sample,
    input  logic             x,
    output logic             done,
    output logic [OUT_W-1:0] sum
);

    localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;

    logic [WIN_LOG2-1:0] samp;
    logic [OUT_W-1:0]    ones;

    // The completing sample must be folded in combinationally so the result
    // register captures all N bits on the same edge.
    assign sum  = ones + {{(OUT_W-1){1'b0}}, x};
    assign done = sample && (samp == SAMP_LAST);

    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values, so the order of statements here does not matter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            samp <= '0;
            ones <= '0;
        end else if (clear) begin
            samp <= '0;
            ones <= '0;
        end else if (sample) begin
            // samp wraps to zero by itself at the end of the window.
            samp <= samp + 1'b1;
            ones <= done ? '0 : sum;
        end
    end

endmodule

// File: rtl/stoch_decode.sv
// stoch_decode
// Windowed stochastic-to-binary decoder with a one-entry valid/ready output.
//   CLK       in   clock
//   nRST      in   asynchronous active-low reset
//   en        in   sample enable
//   x         in   stochastic bitstream
//   clear     in   synchronous clear of window, output buffer and overrun flag
//   y         out  ones count of the last completed window (estimate = y/N)
//   y_valid   out  y holds an unconsumed result
//   y_ready   in   consumer accepts y when y_valid=1
//   y_overrun out  sticky: a result was overwritten before being consumed
module stoch_decode
    import stoch_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    localparam int OUT_W   = out_width(WIN_LOG2)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             x,
    input  logic             clear,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_overrun
);

    stoch_dec_state_t state;

    logic             sample;
    logic             done;
    logic [OUT_W-1:0] sum;
    logic             handshake;

    // clear overrides en on its edge, so the window never sees that sample.
    assign sample    = en && !clear;
    assign handshake = y_valid && y_ready;

    stoch_ones_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_counter (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (clear),
        .sample (sample),
        .x      (x),
        .done   (done),
        .sum    (sum)
    );

    // Control FSM: tracks whether a window is idle, running or paused.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en)  state <= RUN;
                RUN:     if (!en) state <= PAUSE;
                PAUSE:   if (en)  state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output buffer with sticky overrun.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            y         <= '0;
            y_valid   <= 1'b0;
            y_overrun <= 1'b0;
        end else if (clear) begin
            y         <= '0;
            y_valid   <= 1'b0;
            y_overrun <= 1'b0;
        end else if (done) begin
            y       <= sum;
            y_valid <= 1'b1;
            // Only a pending, unaccepted result is lost; a same-edge
            // handshake frees the slot in time for the new one.
            if (y_valid && !y_ready) begin
                y_overrun <= 1'b1;
            end
        end else if (handshake) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stoch_decode.sv
// tb_stoch_decode
// Directed bench for stoch_decode with WIN_LOG2=3 (N=8, 4-bit result).
module tb_stoch_decode;

    localparam int WIN_LOG2 = 3;
    localparam int OUT_W    = WIN_LOG2 + 1;

    logic             CLK;
    logic             nRST;
    logic             en;
    logic             x;
    logic             clear;
    logic [OUT_W-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             y_overrun;

    int total;
    int bad;

    stoch_decode #(
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .en        (en),
        .x         (x),
        .clear     (clear),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_overrun (y_overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int ey, input logic ev, input logic eo);
        check({tag, ".y"}, 16'(y), 16'(ey));
        check({tag, ".valid"}, 16'(y_valid), 16'(ev));
        check({tag, ".overrun"}, 16'(y_overrun), 16'(eo));
    endtask

    // Drive inputs, let one rising edge pass, then settle 1 time unit.
    task automatic step(input logic e, input logic xi, input logic rdy);
        en      = e;
        x       = xi;
        y_ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        total   = 0;
        bad     = 0;
        nRST    = 1'b0;
        en      = 1'b0;
        x       = 1'b0;
        clear   = 1'b0;
        y_ready = 1'b0;

        // Reset state.
        #2;
        check_out("reset", 0, 1'b0, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // All ones, ready high: y=8 on the 8th sample, again 8 later.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
        check("ones_w1_pre", 16'(y_valid), 16'd0);
        step(1'b1, 1'b1, 1'b1);
        check_out("ones_w1", 8, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
        check("ones_w2_pre", 16'(y_valid), 16'd0);
        step(1'b1, 1'b1, 1'b1);
        check_out("ones_w2", 8, 1'b1, 1'b0);

        // Alternating 1010...: y=4.
        for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0), 1'b1);
        check_out("alt", 4, 1'b1, 1'b0);

        // All zero: y=0 with a fresh valid.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        check_out("zeros", 0, 1'b1, 1'b0);

        // Pause mid-window: 3 ones, 5 idle cycles with x=1, 5 zero samples.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        check("pause_hold", 16'(y_valid), 16'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        check("pause_pre", 16'(y_valid), 16'd0);
        step(1'b1, 1'b0, 1'b1);
        check_out("pause", 3, 1'b1, 1'b0);

        // Consume, then hold ready low across two completions.
        step(1'b0, 1'b0, 1'b1);
        check("drain", 16'(y_valid), 16'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        check_out("ovr_first", 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        check_out("ovr_second", 0, 1'b1, 1'b1);

        // Clear wins over en on its edge.
        clear = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        clear = 1'b0;
        check_out("clear", 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        check_out("post_clear", 8, 1'b1, 1'b0);

        // Handshake coincident with completion: new y, valid stays, no overrun.
        pat = 8'b0000_0011;
        for (int i = 0; i < 7; i++) step(1'b1, pat[i], 1'b0);
        check_out("hs_pre", 8, 1'b1, 1'b0);
        step(1'b1, pat[7], 1'b1);
        check_out("hs_same_edge", 2, 1'b1, 1'b0);

        // Async reset mid-window with a pending result.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        check_out("async_rst", 0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check_out("rst_hold", 0, 1'b0, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        pat = 8'b0001_1111;
        for (int i = 0; i < 7; i++) step(1'b1, pat[i], 1'b1);
        check("after_rst_pre", 16'(y_valid), 16'd0);
        step(1'b1, pat[7], 1'b1);
        check_out("after_rst", 5, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stoch_decode.md
# stoch_decode

Windowed stochastic-to-binary decoder that sits directly downstream of the stochastic dot-product stage. It consumes that stage's single-bit output stream and counts ones over fixed windows of 2^WIN_LOG2 sampled cycles. Each completed count is presented as an unsigned fixed-point estimate on a valid/ready output port. Windows run back to back with no dead cycles, and an overrun flag marks results lost to back-pressure.

## Interface
- WIN_LOG2, default 8: log2 of window length N (N = 2^WIN_LOG2); legal range 1..16.
- OUT_W, derived localparam = WIN_LOG2+1: result width, so the count N fits exactly.

- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; x is sampled on each edge where en=1.
- x  in  1  stochastic bitstream (upstream y).
- clear  in  1  synchronous clear of window, output buffer and overrun flag.
- y  out  OUT_W  ones count of the last completed window; value/N = estimate.
- y_valid  out  1  y holds an unconsumed result.
- y_ready  in  1  consumer accepts y on an edge where y_valid=1 and y_ready=1.
- y_overrun  out  1  sticky: a result was overwritten before being consumed.

## Operation
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: counters zero. en=1 -> RUN (that edge's x is sampled).
  - RUN: en=0 -> PAUSE.
  - PAUSE: partial window held. en=1 -> RUN.
  - clear=1 from any state -> IDLE.
- Sampling, on each edge with en=1 and clear=0:
  - ones += x.
  - samp += 1. samp is WIN_LOG2 bits and wraps naturally.
- Window completion is the edge where samp == N-1 and a sample is taken:
  - y <= ones + x.
  - ones <= 0 and samp <= 0 (via the wrap).
  - y_valid <= 1.
  - The next window starts on the following sampled cycle.
- ones is OUT_W bits wide. The maximum value N is exact; no saturation logic is needed.
- Output buffer holds one entry.
  - A handshake with no completion on the same edge clears y_valid.
  - A completion with y_valid=0, or with a handshake on the same edge: load y, y_valid=1, no overrun.
  - A completion with y_valid=1 and y_ready=0: overwrite y, y_valid stays 1, y_overrun <= 1.
- y_overrun clears only on clear or reset.
- clear has priority over sampling, completion and handshake. On that edge: ones=0, samp=0, y_valid=0, y_overrun=0, y=0, state IDLE.
- en is ignored on the clear edge.

## Timing
- Reset (async assert): y=0, y_valid=0, y_overrun=0, state IDLE, counters 0. These take effect immediately, with no clock needed.
- Reset release is synchronous to the CLK edge.
- Latency: y_valid rises at the edge that samples the Nth bit of a window. The result is visible in the cycle after that sample.
- With en held at 1, results arrive every N cycles.
- y and y_valid are registered; no combinational path from x, en or y_ready to the outputs.
- Reset mid-window discards the partial window. Reset with y_valid=1 discards the pending result.
- clear mid-window behaves the same as reset, but synchronously.

## Structure
- Package stoch_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} stoch_dec_state_t.
  - Helper localparam function for OUT_W.
- Sub-module stoch_ones_counter holds samp/ones accumulation and the completion pulse, parameterised by WIN_LOG2.
- The top level holds the FSM, the output buffer and the overrun logic.

## Test plan
- WIN_LOG2=3, en=1, x=1 constant, y_ready=1:
  - y=8 with y_valid rising after the 8th sample.
  - Repeats every 8 cycles.
  - y_overrun=0.
- x=1010... for 8 sampled cycles: y=4. All-zero x: y=0.
- Pause mid-window, WIN_LOG2=3:
  - Stimulus: 3 samples with x=1, then en=0 for 5 cycles with x=1, then 5 samples with x=0.
  - Expected: y=3, and the result arrives only after 8 sampled edges.
- y_ready=0 across two completions (first window x=1 giving 8, second x=0 giving 0):
  - y=0, y_valid=1, y_overrun=1.
  - Then clear=1: y_valid=0, y_overrun=0, y=0.
- y_ready=1 on the same edge as a completion while y_valid=1:
  - New y loaded, y_valid stays 1, y_overrun stays 0.
- nRST asserted between clock edges mid-window with y_valid=1:
  - Outputs drop to 0 before the next edge.
  - After release, the first result reflects only post-reset samples.
